// File: rtl/div4b_seq.sv
// Sequential restoring divider: zi = xi / yi, ri = xi % yi, one shift/trial-subtract per clock.
// Latency: done pulses WIDTH edges after the init edge (1 edge for a zero divisor).
// Backpressure: none; init is ignored while busy, so the caller waits for done.
module div4b_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [WIDTH-1:0] xi,
    input  logic [WIDTH-1:0] yi,
    output logic [WIDTH-1:0] zi,
    output logic [WIDTH-1:0] ri,
    output logic             done,
    output logic             busy,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    // The partial remainder is always below d, so its extra top bit is
    // implicitly zero and only exists inside the shifted trial value.
    logic [WIDTH-1:0] r;
    logic [CW-1:0]    count;
    logic             dz_pend;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   t;
    logic             no_borrow;
    logic [WIDTH-1:0] r_nx;
    logic [WIDTH-1:0] q_nx;

    always_comb begin
        r_sh      = {r, q[WIDTH-1]};
        t         = r_sh - {1'b0, d};
        no_borrow = ~t[WIDTH];
        r_nx      = no_borrow ? t[WIDTH-1:0] : r_sh[WIDTH-1:0];
        q_nx      = {q[WIDTH-2:0], no_borrow};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            q       <= '0;
            d       <= '0;
            r       <= '0;
            count   <= '0;
            dz_pend <= 1'b0;
            zi      <= '0;
            ri      <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            dz      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (init) begin
                        q       <= xi;
                        d       <= yi;
                        r       <= '0;
                        // A zero divisor spends a single CALC cycle so its
                        // result still appears one edge after init.
                        dz_pend <= (yi == '0);
                        count   <= (yi == '0) ? '0 : CW'(WIDTH - 1);
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    q     <= q_nx;
                    r     <= r_nx;
                    count <= count - CW'(1);
                    if (count == '0) begin
                        zi    <= dz_pend ? '1 : q_nx;
                        ri    <= dz_pend ? q : r_nx;
                        dz    <= dz_pend;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
